// File: rtl/score_argmax_pkg.sv
// Shared types and helpers for the score argmax stage behind the adder tree.
package score_argmax_pkg;

    localparam int unsigned SCORE_W = 26;

    typedef logic signed [SCORE_W-1:0] score_t;

    // Class-index width for n classes; never narrower than one bit.
    function automatic int unsigned class_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Valid-tag shift register matched to a fixed pipeline latency, with synchronous clear.
module valid_delay_line #(
    parameter int unsigned DEPTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] taps;

    // Clear also swallows the tag entering this cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            taps <= '0;
        end else begin
            taps <= DEPTH'({taps, din});
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/score_argmax.sv
// Running signed argmax over one frame of class scores, with a held valid/ack result register.
module score_argmax
    import score_argmax_pkg::*;
#(
    parameter int unsigned WIDTH        = SCORE_W,
    parameter int unsigned NUM_CLASSES  = 10,
    parameter int unsigned IDX_W        = class_idx_w(NUM_CLASSES),
    parameter int unsigned TREE_LATENCY = 5
) (
    input  logic                    clk,
    input  logic                    GlobalReset,
    input  logic                    in_valid,
    input  logic                    frame_clear,
    input  logic signed [WIDTH-1:0] Result_1,
    output logic                    out_valid,
    output logic [IDX_W-1:0]        out_class,
    output logic [WIDTH-1:0]        out_score,
    input  logic                    out_ack,
    output logic                    overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic                    score_v;
    logic [IDX_W-1:0]        cnt;
    logic [IDX_W-1:0]        best_idx;
    logic signed [WIDTH-1:0] best_score;

    logic                    take_c;
    logic                    commit_c;
    logic                    load_c;
    logic [IDX_W-1:0]        win_idx_c;
    logic signed [WIDTH-1:0] win_score_c;

    valid_delay_line #(
        .DEPTH (TREE_LATENCY)
    ) u_valid_delay (
        .clk   (clk),
        .rst   (GlobalReset),
        .clear (frame_clear),
        .din   (in_valid),
        .dout  (score_v)
    );

    // First score of a frame always seeds; later ones must strictly exceed so ties keep the lower index.
    always_comb begin
        take_c      = (cnt == '0) || (Result_1 > best_score);
        win_idx_c   = take_c ? cnt : best_idx;
        win_score_c = take_c ? Result_1 : best_score;
        commit_c    = score_v && (cnt == LAST_IDX) && !frame_clear;
        load_c      = commit_c && (!out_valid || out_ack);
    end

    always_ff @(posedge clk) begin
        if (GlobalReset || frame_clear) begin
            cnt        <= '0;
            best_idx   <= '0;
            best_score <= '0;
        end else if (score_v) begin
            cnt        <= (cnt == LAST_IDX) ? '0 : IDX_W'(cnt + 1'b1);
            best_idx   <= win_idx_c;
            best_score <= win_score_c;
        end
    end

    // A commit into a full, unacknowledged register is dropped and flagged.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            out_valid <= 1'b0;
            out_class <= '0;
            out_score <= '0;
            overrun   <= 1'b0;
        end else if (load_c) begin
            out_valid <= 1'b1;
            out_class <= win_idx_c;
            out_score <= win_score_c;
        end else if (commit_c) begin
            overrun   <= 1'b1;
        end else if (out_valid && out_ack) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_score_argmax.sv
// Directed scoreboard bench for score_argmax: frames, ties, overrun, clears and reset.
module tb_score_argmax;
    import score_argmax_pkg::*;

    localparam int unsigned NCLS     = 10;
    localparam int unsigned TREE_LAT = 5;
    localparam int          SCALE    = 65536;

    typedef struct packed {
        logic [3:0]         cls;
        logic [SCORE_W-1:0] score;
    } exp_t;

    logic               clk = 1'b0;
    logic               GlobalReset;
    logic               in_valid;
    logic               frame_clear;
    score_t             Result_1;
    logic               out_valid;
    logic [3:0]         out_class;
    logic [SCORE_W-1:0] out_score;
    logic               out_ack;
    logic               overrun;

    exp_t   sb[$];
    score_t tab[NCLS];
    int     n_cmp = 0;
    int     n_err = 0;

    int t_main[NCLS] = '{3, -7, 12, 12, 0, 5, -1, 8, 11, 2};
    int t_b[NCLS]    = '{1, 1, 1, 1, 1, 9, 1, 1, 1, 1};
    int t_hi[NCLS]   = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
    int t_last9[NCLS] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 20};

    score_argmax #(
        .WIDTH        (SCORE_W),
        .NUM_CLASSES  (NCLS),
        .IDX_W        (4),
        .TREE_LATENCY (TREE_LAT)
    ) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .in_valid    (in_valid),
        .frame_clear (frame_clear),
        .Result_1    (Result_1),
        .out_valid   (out_valid),
        .out_class   (out_class),
        .out_score   (out_score),
        .out_ack     (out_ack),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        Result_1 = score_t'($urandom);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int v[NCLS]);
        for (int i = 0; i < int'(NCLS); i++) tab[i] = score_t'(v[i] * SCALE);
    endtask

    task automatic load_raw(input score_t v);
        for (int i = 0; i < int'(NCLS); i++) tab[i] = v;
    endtask

    // Drives n tagged operands gap cycles apart and the tree's scores TREE_LAT later;
    // returns in the cycle carrying the last score.
    task automatic run_frame(input int n, input int gap, input bit push);
        int   per;
        int   last;
        int   k;
        exp_t e;
        per  = gap + 1;
        last = (n - 1) * per + int'(TREE_LAT);
        for (int c = 0; c <= last; c++) begin
            if (c > 0) step();
            in_valid = (c % per == 0) && (c / per < n);
            k = (c - int'(TREE_LAT)) / per;
            if (c >= int'(TREE_LAT) && (c - int'(TREE_LAT)) % per == 0 && k < n)
                Result_1 = tab[k];
            else
                Result_1 = score_t'($urandom);
        end
        if (push) begin
            e.cls   = 4'd0;
            e.score = tab[0];
            for (int i = 1; i < n; i++) begin
                if (tab[i] > score_t'(e.score)) begin
                    e.cls   = 4'(i);
                    e.score = tab[i];
                end
            end
            sb.push_back(e);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL %s_sb: observed result with empty queue expected none", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_class"}, 64'(out_class), 64'(e.cls));
            chk({tag, "_score"}, 64'(out_score), 64'(e.score));
        end
    endtask

    task automatic ack_out(input string tag);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk({tag, "_ack_clear"}, 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        GlobalReset = 1'b1;
        step();
        chk({tag, "_rst_valid"},   64'(out_valid), 64'd0);
        chk({tag, "_rst_class"},   64'(out_class), 64'd0);
        chk({tag, "_rst_score"},   64'(out_score), 64'd0);
        chk({tag, "_rst_overrun"}, 64'(overrun),   64'd0);
        GlobalReset = 1'b0;
        step();
    endtask

    initial begin
        GlobalReset = 1'b1;
        in_valid    = 1'b0;
        frame_clear = 1'b0;
        out_ack     = 1'b0;
        Result_1    = '0;
        step();
        do_reset("init");

        // Back-to-back frame with a tie at the maximum; exact commit latency.
        load(t_main);
        run_frame(int'(NCLS), 0, 1'b1);
        chk("t1_early", 64'(out_valid), 64'd0);
        step();
        check_out("t1");
        ack_out("t1");
        step();
        chk("t1_ack_idle", 64'(out_valid), 64'd0);

        // All scores at the most negative value.
        load_raw(score_t'(26'h2000000));
        run_frame(int'(NCLS), 0, 1'b1);
        step();
        check_out("t2");
        ack_out("t2");

        // Second commit into a held result: dropped, overrun sticky.
        load(t_main);
        run_frame(int'(NCLS), 0, 1'b1);
        step();
        check_out("t3a_first");
        load(t_b);
        run_frame(int'(NCLS), 0, 1'b0);
        step();
        chk("t3a_overrun",    64'(overrun),   64'd1);
        chk("t3a_held_valid", 64'(out_valid), 64'd1);
        chk("t3a_held_class", 64'(out_class), 64'd2);
        chk("t3a_held_score", 64'(out_score), 64'(26'(12 * SCALE)));
        ack_out("t3a");
        step();
        chk("t3a_sticky", 64'(overrun), 64'd1);
        do_reset("t3");

        // Ack in the commit cycle swaps results without overrun.
        load(t_main);
        run_frame(int'(NCLS), 0, 1'b1);
        step();
        check_out("t3b_first");
        load(t_b);
        run_frame(int'(NCLS), 0, 1'b1);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        check_out("t3b_second");
        chk("t3b_overrun", 64'(overrun), 64'd0);
        ack_out("t3b");

        // Abort a partial frame, then a fresh frame peaking at the last class.
        load(t_hi);
        run_frame(4, 0, 1'b0);
        step();
        frame_clear = 1'b1;
        step();
        frame_clear = 1'b0;
        load(t_last9);
        run_frame(int'(NCLS), 0, 1'b1);
        step();
        check_out("t4");
        ack_out("t4");
        for (int i = 0; i < 8; i++) step();
        chk("t4_single", 64'(out_valid), 64'd0);

        // Clear coinciding with the committing score wins.
        load(t_main);
        run_frame(int'(NCLS), 0, 1'b0);
        frame_clear = 1'b1;
        step();
        frame_clear = 1'b0;
        chk("t4_clear_wins", 64'(out_valid), 64'd0);

        // Gapped operands with garbage between scores.
        load(t_main);
        run_frame(int'(NCLS), 3, 1'b1);
        step();
        check_out("t5");
        ack_out("t5");

        // Reset while holding a result, with overrun set and a frame in flight.
        load(t_main);
        run_frame(int'(NCLS), 0, 1'b1);
        step();
        check_out("t6_held");
        load(t_b);
        run_frame(int'(NCLS), 0, 1'b0);
        step();
        chk("t6_overrun", 64'(overrun), 64'd1);
        load(t_main);
        run_frame(5, 0, 1'b0);
        do_reset("t6");
        load(t_last9);
        run_frame(int'(NCLS), 0, 1'b1);
        step();
        check_out("t6_after");
        chk("t6_after_overrun", 64'(overrun), 64'd0);
        ack_out("t6");

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
